// File: rtl/enc_frame_pack.sv
// enc_frame_pack
//   Packs every PKT_LEN valid FIR beats (data + encoder word) into one packet. Each
//   packet is preceded by a generated header beat. Packets leave on an AXI-Stream-style
//   master port. The input has no backpressure, so admission is decided per packet on
//   its first beat: a packet that cannot fit whole in the buffer is dropped whole.
//
//   Handshake: a beat transfers on a rising edge where m_tvalid && m_tready. While
//   m_tvalid=1 and m_tready=0, m_tdata/m_tuser/m_tlast stay stable.
//
//   Optional feature macro: FRAME_PACK_STAT_EN
//     defined   -> drop_cnt port and saturating drop counter; header [95:80] = drop_cnt
//                  captured when the header is presented.
//     undefined -> no drop_cnt port; header [95:80] = 0.
//
// Ports
//   clk       in   1        clock
//   rst       in   1        asynchronous active-high reset
//   cfg_rst   in   1        synchronous soft clear (same effect as rst)
//   fir_ivld  in   1        input beat valid
//   fir_idat  in   DATA_WD  FIR data beat
//   enc_idat  in   HEAD_WD  encoder word
//   m_tvalid  out  1        output beat valid
//   m_tready  in   1        downstream ready
//   m_tdata   out  DATA_WD  header or data beat
//   m_tuser   out  1        1 = header beat
//   m_tlast   out  1        1 = last data beat of packet
//   drop_cnt  out  16       dropped packets, saturating (FRAME_PACK_STAT_EN only)
module enc_frame_pack #(
    parameter int DATA_WD    = 512,
    parameter int HEAD_WD    = 64,
    parameter int PKT_LEN    = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_rst,
    input  logic               fir_ivld,
    input  logic [DATA_WD-1:0] fir_idat,
    input  logic [HEAD_WD-1:0] enc_idat,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [DATA_WD-1:0] m_tdata,
    output logic               m_tuser,
    output logic               m_tlast
`ifdef FRAME_PACK_STAT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int IDX_W = $clog2(PKT_LEN);
    // Entry layout: {sop, pkt_seq, enc[63:0], data}
    localparam int ENT_W = 1 + 16 + 64 + DATA_WD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_DATA = 2'd2
    } state_t;

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [IDX_W-1:0] in_cnt_q;
    logic             admit_q;
    logic [15:0]      pkt_seq_q;
    logic [IDX_W-1:0] out_idx_q;
    state_t           state_q, state_d;

    logic             beat0, has_room, wr_en, rd_en, last_beat;
    logic [15:0]      seq_w;
    logic [ENT_W-1:0] head_ent;
    logic [DATA_WD-1:0] head_data;
    logic [63:0]      head_enc;
    logic [15:0]      head_seq;
    logic             head_sop;
    logic [15:0]      hdr_drop;

    // ---------------- input side / admission ----------------
    assign beat0    = fir_ivld && (in_cnt_q == '0);
    // Free space is judged on the registered level only; a same-cycle pop is ignored.
    assign has_room = (LVL_W'(FIFO_DEPTH) - level_q) >= LVL_W'(PKT_LEN);
    assign wr_en    = fir_ivld && (beat0 ? has_room : admit_q);
    // Sequence number for beat 0 is the post-increment value; later beats already see it.
    assign seq_w    = beat0 ? pkt_seq_q + 16'd1 : pkt_seq_q;

    assign rd_en    = (state_q == S_DATA) && (level_q != '0) && m_tready;
    assign level_d  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);

    assign head_ent  = mem[rd_ptr_q];
    assign head_data = head_ent[DATA_WD-1:0];
    assign head_enc  = head_ent[DATA_WD +: 64];
    assign head_seq  = head_ent[DATA_WD+64 +: 16];
    assign head_sop  = head_ent[ENT_W-1];
    assign last_beat = (out_idx_q == IDX_W'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (wr_en && !cfg_rst) begin
            mem[wr_ptr_q] <= {beat0, seq_w, enc_idat[63:0], fir_idat};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_cnt_q  <= '0;
            admit_q   <= 1'b0;
            pkt_seq_q <= '0;
        end else if (cfg_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            in_cnt_q  <= '0;
            admit_q   <= 1'b0;
            pkt_seq_q <= '0;
        end else begin
            if (fir_ivld) begin
                in_cnt_q <= (in_cnt_q == IDX_W'(PKT_LEN - 1)) ? '0 : in_cnt_q + 1'b1;
                if (beat0) begin
                    admit_q <= has_room;
                    if (has_room) pkt_seq_q <= pkt_seq_q + 16'd1;
                end
            end
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

`ifdef FRAME_PACK_STAT_EN
    logic [15:0] drop_cnt_q, hdr_drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
            hdr_drop_q <= '0;
        end else if (cfg_rst) begin
            drop_cnt_q <= '0;
            hdr_drop_q <= '0;
        end else begin
            if (beat0 && !has_room && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            // Captured on entry to HEAD so the header stays stable while stalled.
            if ((state_d == S_HEAD) && (state_q != S_HEAD)) hdr_drop_q <= drop_cnt_q;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign hdr_drop = hdr_drop_q;
`else
    assign hdr_drop = 16'h0;
`endif

    // ---------------- output FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (cfg_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if ((level_q != '0) && head_sop) state_d = S_HEAD;
            S_HEAD:  if (m_tready) state_d = S_DATA;
            // Next state looks at the post-pop level so a queued packet follows with no gap.
            S_DATA:  if (rd_en && last_beat) state_d = (level_d != '0) ? S_HEAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx_q <= '0;
        end else if (cfg_rst) begin
            out_idx_q <= '0;
        end else if (state_q == S_HEAD) begin
            out_idx_q <= '0;
        end else if (rd_en) begin
            out_idx_q <= last_beat ? '0 : out_idx_q + 1'b1;
        end
    end

    always_comb begin
        m_tvalid = 1'b0;
        m_tuser  = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        case (state_q)
            S_HEAD: begin
                m_tvalid        = 1'b1;
                m_tuser         = 1'b1;
                m_tdata[63:0]   = head_enc;
                m_tdata[79:64]  = head_seq;
                m_tdata[95:80]  = hdr_drop;
                m_tdata[111:96] = 16'(PKT_LEN);
            end
            S_DATA: begin
                // Empty buffer mid-packet is a bubble; the FSM stays in DATA.
                if (level_q != '0) begin
                    m_tvalid = 1'b1;
                    m_tdata  = head_data;
                    m_tlast  = last_beat;
                end
            end
            default: ;
        endcase
    end

endmodule
